// File: rtl/fetch_sequencer_if.sv
// Bundles the PC control, instruction-memory and decode handshake signals.
// The sequencer side uses the master modport; the environment uses the slave modport.
interface fetch_sequencer_if #(
  parameter int DATA_W = 16
);
  logic              fetch_start;
  logic              fetch_halt;
  logic              fetch_busy;
  logic [DATA_W-1:0] pc_value;
  logic              pc_rd_en;
  logic              pc_wr_en;
  logic [DATA_W-1:0] pc_load_val;
  logic              pc_count;
  logic              pc_dir;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_rd_req;
  logic              mem_rd_ack;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] ir_out;
  logic              ir_valid;
  logic              ir_ready;

  modport master (
    input  fetch_start, fetch_halt, pc_value, mem_rd_ack, mem_rd_data, ir_ready,
    output fetch_busy, pc_rd_en, pc_wr_en, pc_load_val, pc_count, pc_dir,
           mem_addr, mem_rd_req, ir_out, ir_valid
  );

  modport slave (
    output fetch_start, fetch_halt, pc_value, mem_rd_ack, mem_rd_data, ir_ready,
    input  fetch_busy, pc_rd_en, pc_wr_en, pc_load_val, pc_count, pc_dir,
           mem_addr, mem_rd_req, ir_out, ir_valid
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: reads the PC, fetches a word, resolves the two jump
// forms internally and hands ordinary instructions to decode over valid/ready.
module fetch_sequencer #(
  parameter int          DATA_W      = 16,
  parameter logic [3:0]  JMP_ABS_OPC = 4'hC,
  parameter logic [3:0]  BR_IMM_OPC  = 4'hD
) (
  input  logic            fetch_clk,
  input  logic            fetch_rst,
  fetch_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    IDLE,
    PC_RD,
    PC_WAIT,
    MEM_REQ,
    DECODE,
    TGT_REQ,
    JUMP,
    ISSUE,
    ADVANCE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_pc_rd_en;
  logic              r_pc_wr_en;
  logic              r_pc_count;
  logic [DATA_W-1:0] r_pc_load_val;
  logic [DATA_W-1:0] r_mem_addr;
  logic              r_mem_rd_req;
  logic [DATA_W-1:0] r_ir_out;
  logic              r_ir_valid;
  logic              r_halt_pending;

  logic [3:0]        w_opcode;
  logic              w_halt;
  logic [DATA_W-1:0] w_branch_target;

  assign w_opcode        = r_ir_out[DATA_W-1 -: 4];
  assign w_branch_target = {{(DATA_W-12){1'b0}}, r_ir_out[11:0]};
  // A halt raised in the very cycle that finishes an instruction still takes effect.
  assign w_halt          = r_halt_pending | bus.fetch_halt;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.fetch_start) w_state_next = PC_RD;
      PC_RD:   w_state_next = PC_WAIT;
      PC_WAIT: w_state_next = MEM_REQ;
      MEM_REQ: if (bus.mem_rd_ack) w_state_next = DECODE;
      DECODE: begin
        if (w_opcode == JMP_ABS_OPC)     w_state_next = TGT_REQ;
        else if (w_opcode == BR_IMM_OPC) w_state_next = JUMP;
        else                             w_state_next = ISSUE;
      end
      TGT_REQ: if (bus.mem_rd_ack) w_state_next = JUMP;
      ISSUE:   if (bus.ir_ready) w_state_next = ADVANCE;
      JUMP, ADVANCE: w_state_next = w_halt ? IDLE : PC_RD;
      default: w_state_next = IDLE;
    endcase
  end

  // Strobes are registered from the next state so each is high exactly while in its state.
  always_ff @(posedge fetch_clk or posedge fetch_rst) begin
    if (fetch_rst) begin
      r_state        <= IDLE;
      r_pc_rd_en     <= 1'b0;
      r_pc_wr_en     <= 1'b0;
      r_pc_count     <= 1'b0;
      r_pc_load_val  <= '0;
      r_mem_addr     <= '0;
      r_mem_rd_req   <= 1'b0;
      r_ir_out       <= '0;
      r_ir_valid     <= 1'b0;
      r_halt_pending <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pc_rd_en   <= (w_state_next == PC_RD);
      r_pc_wr_en   <= (w_state_next == JUMP);
      r_pc_count   <= (w_state_next == ADVANCE);
      r_mem_rd_req <= (w_state_next == MEM_REQ) || (w_state_next == TGT_REQ);
      r_ir_valid   <= (w_state_next == ISSUE);

      if (w_state_next == IDLE)
        r_halt_pending <= 1'b0;
      else if ((r_state != IDLE) && bus.fetch_halt)
        r_halt_pending <= 1'b1;

      unique case (r_state)
        PC_WAIT: r_mem_addr <= bus.pc_value;
        MEM_REQ: if (bus.mem_rd_ack) r_ir_out <= bus.mem_rd_data;
        DECODE: begin
          if (w_opcode == JMP_ABS_OPC)
            r_mem_addr <= r_mem_addr + DATA_W'(1);
          else if (w_opcode == BR_IMM_OPC)
            r_pc_load_val <= w_branch_target;
        end
        TGT_REQ: if (bus.mem_rd_ack) r_pc_load_val <= bus.mem_rd_data;
        default: ;
      endcase
    end
  end

  assign bus.pc_rd_en    = r_pc_rd_en;
  assign bus.pc_wr_en    = r_pc_wr_en;
  assign bus.pc_count    = r_pc_count;
  assign bus.pc_dir      = 1'b0;
  assign bus.pc_load_val = r_pc_load_val;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_rd_req  = r_mem_rd_req;
  assign bus.ir_out      = r_ir_out;
  assign bus.ir_valid    = r_ir_valid;
  assign bus.fetch_busy  = (r_state != IDLE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a PC model, a wait-state memory model
// and a posedge monitor that logs issues, PC strobes and fetch addresses.
`timescale 1ns/1ps
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.DATA_W(16)) bus();

  fetch_sequencer dut (
    .fetch_clk (clk),
    .fetch_rst (rst),
    .bus       (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // PC model: loads on pc_wr_en, steps on pc_count, independent of the DUT reset.
  logic [15:0] pc = 16'h0000;
  logic        pc_pre = 1'b0;
  logic [15:0] pc_pre_val = 16'h0000;
  always @(posedge clk) begin
    if (pc_pre)               pc <= pc_pre_val;
    else if (bus.pc_wr_en)    pc <= bus.pc_load_val;
    else if (bus.pc_count)    pc <= bus.pc_dir ? pc - 16'd1 : pc + 16'd1;
  end
  assign bus.pc_value = pc;

  // Memory model with a programmable number of wait cycles before ack.
  logic [15:0] mem_model [0:65535];
  int          mem_wait = 0;
  int          wait_cnt = 0;
  logic        ack_force = 1'b0;
  assign bus.mem_rd_ack  = ack_force | (bus.mem_rd_req && (wait_cnt >= mem_wait));
  assign bus.mem_rd_data = mem_model[bus.mem_addr];
  always @(posedge clk) begin
    if (bus.mem_rd_req && !bus.mem_rd_ack) wait_cnt <= wait_cnt + 1;
    else                                   wait_cnt <= 0;
  end

  // Monitor
  int          cyc = 0;
  int          n_count = 0;
  int          n_viol = 0;
  logic [15:0] q_ir[$];
  int          q_icyc[$];
  logic [15:0] q_ld[$];
  int          q_wcyc[$];
  int          q_rcyc[$];
  logic [15:0] q_addr[$];
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
  logic [15:0] prev_addr = '0, prev_ir = '0;

  always @(posedge clk) begin
    cyc++;
    if (bus.ir_valid && bus.ir_ready) begin
      q_ir.push_back(bus.ir_out);
      q_icyc.push_back(cyc);
    end
    if (bus.pc_count) n_count++;
    if (bus.pc_wr_en) begin
      q_ld.push_back(bus.pc_load_val);
      q_wcyc.push_back(cyc);
    end
    if (bus.pc_rd_en) q_rcyc.push_back(cyc);
    if (bus.mem_rd_req && bus.mem_rd_ack) q_addr.push_back(bus.mem_addr);
    if (bus.pc_wr_en && bus.pc_count) n_viol++;
    if (prev_req && !prev_ack && (bus.mem_rd_req !== 1'b1 || bus.mem_addr !== prev_addr)) n_viol++;
    if (prev_valid && !prev_ready && (bus.ir_valid !== 1'b1 || bus.ir_out !== prev_ir)) n_viol++;
    prev_req   = bus.mem_rd_req;
    prev_ack   = bus.mem_rd_ack;
    prev_addr  = bus.mem_addr;
    prev_valid = bus.ir_valid;
    prev_ready = bus.ir_ready;
    prev_ir    = bus.ir_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  int wtarget = 0;
  function automatic logic cond(input int sel);
    case (sel)
      0:       return bus.ir_valid;
      1:       return bus.mem_rd_req;
      2:       return !bus.fetch_busy;
      3:       return (q_ir.size() >= wtarget);
      default: return (q_ld.size() >= wtarget);
    endcase
  endfunction

  task automatic wait_for(input int sel, input string tag);
    int k = 0;
    while (!cond(sel) && k < 60) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(cond(sel)), 32'd1);
  endtask

  task automatic clear_logs();
    q_ir.delete(); q_icyc.delete(); q_ld.delete(); q_wcyc.delete();
    q_rcyc.delete(); q_addr.delete();
    n_count = 0;
  endtask

  task automatic preload_pc(input logic [15:0] v);
    pc_pre_val = v;
    pc_pre = 1'b1;
    @(negedge clk);
    pc_pre = 1'b0;
  endtask

  task automatic pulse_start();
    bus.fetch_start = 1'b1;
    @(negedge clk);
    bus.fetch_start = 1'b0;
  endtask

  task automatic pulse_halt();
    bus.fetch_halt = 1'b1;
    @(negedge clk);
    bus.fetch_halt = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.fetch_start = 1'b0;
    bus.fetch_halt  = 1'b0;
    bus.ir_ready    = 1'b1;
    mem_model[16'h0000] = 16'h1234;
    mem_model[16'h0001] = 16'h2345;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_strobes", {25'd0, bus.pc_rd_en, bus.pc_wr_en, bus.pc_count, bus.pc_dir,
                          bus.mem_rd_req, bus.ir_valid, bus.fetch_busy}, 32'd0);
    check("rst_regs", {bus.mem_addr, bus.ir_out | bus.pc_load_val}, 32'd0);
    rst = 1'b0;
    preload_pc(16'h0000);

    // Sequential fetch, zero wait, halt during the second MEM_REQ
    clear_logs();
    pulse_start();
    wtarget = 1;
    wait_for(3, "seq_issue1");
    wait_for(1, "seq_req2");
    pulse_halt();
    wait_for(2, "seq_idle");
    check("seq_ir0", 32'(q_ir[0]), 32'h1234);
    check("seq_ir1", 32'(q_ir[1]), 32'h2345);
    check("seq_period", 32'(q_icyc[1] - q_icyc[0]), 32'd6);
    check("seq_counts", 32'(n_count), 32'd2);
    check("seq_pc", 32'(pc), 32'h0002);

    // Immediate branch
    mem_model[16'h0000] = 16'hD0A5;
    mem_model[16'h00A5] = 16'h1111;
    preload_pc(16'h0000);
    clear_logs();
    pulse_start();
    wtarget = 1;
    wait_for(4, "br_jump");
    wait_for(1, "br_req2");
    pulse_halt();
    wait_for(2, "br_idle");
    check("br_loadval", 32'(q_ld[0]), 32'h00A5);
    check("br_latency", 32'(q_wcyc[0] - q_rcyc[0]), 32'd4);
    check("br_issues", 32'(q_ir.size()), 32'd1);
    check("br_ir", 32'(q_ir[0]), 32'h1111);
    check("br_addr1", 32'(q_addr[1]), 32'h00A5);
    check("br_pc", 32'(pc), 32'h00A6);

    // Absolute jump with address wrap
    mem_model[16'hFFFF] = 16'hC000;
    mem_model[16'h0000] = 16'hBEEF;
    mem_model[16'hBEEF] = 16'h2222;
    preload_pc(16'hFFFF);
    clear_logs();
    pulse_start();
    wtarget = 1;
    wait_for(4, "abs_jump");
    wait_for(1, "abs_req2");
    pulse_halt();
    wait_for(2, "abs_idle");
    check("abs_addr0", 32'(q_addr[0]), 32'hFFFF);
    check("abs_tgtaddr", 32'(q_addr[1]), 32'h0000);
    check("abs_loadval", 32'(q_ld[0]), 32'hBEEF);
    check("abs_latency", 32'(q_wcyc[0] - q_rcyc[0]), 32'd5);
    check("abs_fetch", 32'(q_addr[2]), 32'hBEEF);
    check("abs_issues", 32'(q_ir.size()), 32'd1);
    check("abs_pc", 32'(pc), 32'hBEF0);

    // Backpressure and memory wait states
    mem_model[16'h0010] = 16'h3333;
    mem_model[16'h0011] = 16'h4444;
    mem_wait = 3;
    bus.ir_ready = 1'b0;
    preload_pc(16'h0010);
    clear_logs();
    pulse_start();
    for (int k = 0; k < 2; k++) begin
      wait_for(0, "bp_valid");
      repeat (4) @(negedge clk);
      check("bp_nocount", 32'(n_count), 32'(k));
      bus.ir_ready = 1'b1;
      if (k == 1) bus.fetch_halt = 1'b1;
      @(negedge clk);
      bus.ir_ready = 1'b0;
      bus.fetch_halt = 1'b0;
    end
    wait_for(2, "bp_idle");
    check("bp_ir0", 32'(q_ir[0]), 32'h3333);
    check("bp_ir1", 32'(q_ir[1]), 32'h4444);
    check("bp_period", 32'(q_icyc[1] - q_icyc[0]), 32'd13);
    check("bp_counts", 32'(n_count), 32'd2);
    check("bp_pc", 32'(pc), 32'h0012);
    check("hold_viol", 32'(n_viol), 32'd0);

    // Halt during MEM_REQ, then restart with a halt pulse in IDLE ignored
    mem_model[16'h0020] = 16'h5555;
    mem_model[16'h0021] = 16'h6666;
    mem_model[16'h0022] = 16'h7777;
    mem_wait = 2;
    bus.ir_ready = 1'b1;
    preload_pc(16'h0020);
    clear_logs();
    pulse_start();
    wait_for(1, "halt_req");
    pulse_halt();
    wait_for(2, "halt_idle");
    check("halt_issues", 32'(q_ir.size()), 32'd1);
    check("halt_ir", 32'(q_ir[0]), 32'h5555);
    check("halt_pc", 32'(pc), 32'h0021);
    pulse_halt();
    clear_logs();
    pulse_start();
    wtarget = 1;
    wait_for(3, "rs_issue1");
    wait_for(1, "rs_req2");
    pulse_halt();
    wait_for(2, "rs_idle");
    check("rs_addr0", 32'(q_addr[0]), 32'h0021);
    check("rs_ir0", 32'(q_ir[0]), 32'h6666);
    check("rs_ir1", 32'(q_ir[1]), 32'h7777);
    check("rs_pc", 32'(pc), 32'h0023);

    // Asynchronous reset in the middle of a memory wait
    mem_wait = 1000;
    preload_pc(16'h0030);
    clear_logs();
    pulse_start();
    wait_for(1, "ar_req");
    #2 rst = 1'b1;
    #1;
    check("ar_req_now", 32'(bus.mem_rd_req), 32'd0);
    check("ar_busy_now", 32'(bus.fetch_busy), 32'd0);
    check("ar_regs_now", {bus.mem_addr, bus.ir_out | bus.pc_load_val}, 32'd0);
    #3 rst = 1'b0;
    @(negedge clk);
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    repeat (3) @(negedge clk);
    check("ar_late_ack", {29'd0, bus.fetch_busy, bus.mem_rd_req, bus.ir_valid}, 32'd0);
    check("ar_no_issue", 32'(q_ir.size()), 32'd0);
    check("ar_ir", 32'(bus.ir_out), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
